// File: rtl/emif_pkg.sv
// Shared types and constants for the asynchronous EMIF initiator.
package emif_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } emif_state_t;

  localparam logic        CEN_IDLE    = 1'b1;
  localparam logic [1:0]  BYTEN_IDLE  = 2'b11;
  localparam logic [15:0] TIMEOUT_PAT = 16'hDEAD;

  // Right-rotate by one bit; the capture side left-rotates, so the
  // logical address round-trips unchanged.
  function automatic logic [23:0] ROT_ADDR(input logic [23:0] addr);
    return {addr[0], addr[23:1]};
  endfunction

endpackage

// File: rtl/emif_phase_cnt.sv
// Loadable 8-bit down-counter with a zero flag; times each bus phase.
module emif_phase_cnt (
  input  logic       clk_100m,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  // Load on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/emif_async_master.sv
// Asynchronous 16-bit EMIF initiator: converts a valid/ready request into a
// timed SETUP/STROBE/HOLD/TURN bus cycle. All bus pins are registered.
// Optional macro EMIF_ARDY_EN adds a synchronized ready input that stretches
// STROBE, bounded by a 4095-cycle wait timeout.
module emif_async_master
  import emif_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TA_CYC     = 2
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [23:0] emif_addr_o,
  output logic [15:0] emif_data_o,
  output logic        emif_data_oe,
  input  logic [15:0] emif_data_i,
  output logic [1:0]  emif_byten_o,
  output logic        emif_cen_o,
  output logic        emif_wen_o,
  output logic        emif_oen_o
`ifdef EMIF_ARDY_EN
  ,
  input  logic        emif_ardy_i,
  output logic        ardy_timeout
`endif
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TA_LD     = 8'(TA_CYC - 1);

  emif_state_t state, state_nxt;
  logic        cnt_load;
  logic [7:0]  cnt_val;
  logic        cnt_zero;
  logic        lat_wr;
  logic        hs;
  logic        strobe_done;
  logic        timeout_hit;
  logic        strobe_end;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign hs         = req_valid & req_ready;
  assign strobe_end = (state == STROBE) && strobe_done;

  emif_phase_cnt u_phase_cnt (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

`ifdef EMIF_ARDY_EN
  logic        ardy_p0, ardy_p1;
  logic [11:0] wait_cnt;
  logic        wait_max;

  assign wait_max    = (wait_cnt == 12'hFFF);
  assign strobe_done = cnt_zero & (ardy_p1 | wait_max);
  assign timeout_hit = cnt_zero & ~ardy_p1 & wait_max;

  // Two-flop synchronizer for the asynchronous ready input.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ardy_p0 <= 1'b0;
      ardy_p1 <= 1'b0;
    end else begin
      ardy_p0 <= emif_ardy_i;
      ardy_p1 <= ardy_p0;
    end
  end

  // Count strobe-extension cycles; saturates at the timeout bound.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 12'd0;
    end else if (state != STROBE) begin
      wait_cnt <= 12'd0;
    end else if (cnt_zero && !ardy_p1 && !wait_max) begin
      wait_cnt <= wait_cnt + 12'd1;
    end
  end

  // One-cycle timeout pulse, aligned with the first HOLD cycle.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ardy_timeout <= 1'b0;
    end else begin
      ardy_timeout <= strobe_end & timeout_hit;
    end
  end
`else
  assign strobe_done = cnt_zero;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the phase counter is reloaded on every phase entry.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = 8'd0;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = SETUP;
          cnt_load  = 1'b1;
          cnt_val   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt = STROBE;
          cnt_load  = 1'b1;
          cnt_val   = STROBE_LD;
        end
      end
      STROBE: begin
        if (strobe_done) begin
          state_nxt = HOLD;
          cnt_load  = 1'b1;
          cnt_val   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = TURN;
          cnt_load  = 1'b1;
          cnt_val   = TA_LD;
        end
      end
      TURN: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus pins registered from the upcoming state; request fields captured on handshake.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      emif_cen_o   <= CEN_IDLE;
      emif_wen_o   <= 1'b1;
      emif_oen_o   <= 1'b1;
      emif_byten_o <= BYTEN_IDLE;
      emif_addr_o  <= 24'd0;
      emif_data_o  <= 16'd0;
      emif_data_oe <= 1'b0;
      lat_wr       <= 1'b0;
    end else begin
      case (state_nxt)
        SETUP: begin
          emif_cen_o   <= 1'b0;
          emif_byten_o <= 2'b00;
          emif_wen_o   <= 1'b1;
          emif_oen_o   <= 1'b1;
        end
        STROBE: begin
          emif_wen_o <= ~lat_wr;
          emif_oen_o <= lat_wr;
        end
        HOLD: begin
          emif_wen_o <= 1'b1;
          emif_oen_o <= 1'b1;
        end
        default: begin
          emif_cen_o   <= CEN_IDLE;
          emif_byten_o <= BYTEN_IDLE;
          emif_wen_o   <= 1'b1;
          emif_oen_o   <= 1'b1;
          emif_data_oe <= 1'b0;
        end
      endcase
      if (hs) begin
        lat_wr      <= req_wr;
        emif_addr_o <= ROT_ADDR(req_addr);
        if (req_wr) begin
          emif_data_o  <= req_wdata;
          emif_data_oe <= 1'b1;
        end
      end
    end
  end

  // Read capture on the edge that ends STROBE; response strobes for one cycle.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
    end else begin
      rsp_valid <= 1'b0;
      if (strobe_end && !lat_wr) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= timeout_hit ? TIMEOUT_PAT : emif_data_i;
      end
    end
  end

endmodule
